// File: rtl/debounce_fsm_if.sv
// Interface bundling the debouncer's sample strobe, raw pin level and the
// clean outputs handed to user logic. The debouncer is the slave; whatever
// drives the pin and the timer tick (or a testbench) is the master.
interface debounce_fsm_if;
    logic tick;      // one-cycle sample strobe from the debounce timer
    logic raw_in;    // noisy pin level (asynchronous unless sync is disabled)
    logic db_level;  // debounced level
    logic rise;      // one-cycle pulse on db_level 0->1
    logic fall;      // one-cycle pulse on db_level 1->0
    logic busy;      // qualifying a candidate change

    modport master (
        output tick,
        output raw_in,
        input  db_level,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  tick,
        input  raw_in,
        output db_level,
        output rise,
        output fall,
        output busy
    );
endinterface : debounce_fsm_if

// File: rtl/debounce_fsm.sv
// Debounce state machine: turns a noisy button/switch level into a clean
// registered level plus single-cycle rise/fall pulses. A new level must be
// seen on STABLE_TICKS consecutive timer ticks before it is accepted; any
// bounce back to the current level aborts the qualification.
//
// Optional feature macro: DEBOUNCE_SYNC_EN
//   defined   -> 2-flop synchronizer on raw_in (adds 2 cycles of latency)
//   undefined -> raw_in is used directly (input already synchronous to clk)
module debounce_fsm #(
    parameter int unsigned STABLE_TICKS = 4   // legal range 1..15
) (
    input logic           clk,
    input logic           reset,   // asynchronous, active-low
    debounce_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    // Counter value at which the next tick is the qualifying one. Comparing
    // before incrementing means the 4-bit counter can never wrap.
    localparam logic [3:0] LAST_CNT = 4'(STABLE_TICKS - 1);

    // Reject out-of-range configurations at elaboration time.
    if (STABLE_TICKS < 1 || STABLE_TICKS > 15) begin : g_bad_param
        $error("debounce_fsm: STABLE_TICKS must be in 1..15");
    end

    logic sync_in;

`ifdef DEBOUNCE_SYNC_EN
    logic meta_q;
    logic sync_q;

    // Two-flop synchronizer bringing the asynchronous pin into the clk domain.
    // NOTE: reset only flops whose reset value is observable; here both stages
    // must read 0 after reset so a held button still needs full qualification.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= bus.raw_in;
            sync_q <= meta_q;
        end
    end

    assign sync_in = sync_q;
`else
    assign sync_in = bus.raw_in;
`endif

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;
    logic       busy_q;

    // Debounce FSM with registered outputs; pulses default low every cycle.
    // NOTE: every assignment here is non-blocking so all registers update from
    // the same pre-edge values; blocking would let later lines see new values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= 4'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            unique case (state_q)
                STABLE_LOW: begin
                    // Ticks are ignored while stable; only a level change matters.
                    if (sync_in) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (!sync_in) begin
                        // Bounce back wins over a simultaneous tick.
                        state_q <= STABLE_LOW;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (bus.tick) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= STABLE_HIGH;
                            cnt_q   <= 4'd0;
                            busy_q  <= 1'b0;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end

                STABLE_HIGH: begin
                    if (!sync_in) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end

                WAIT_LOW: begin
                    if (sync_in) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (bus.tick) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= STABLE_LOW;
                            cnt_q   <= 4'd0;
                            busy_q  <= 1'b0;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end

                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_level = level_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.busy     = busy_q;

    // Edge pulses are mutually exclusive and last a single cycle.
    a_pulse_excl: assert property (@(posedge clk) disable iff (!reset)
        !(rise_q && fall_q));
    a_rise_one: assert property (@(posedge clk) disable iff (!reset)
        rise_q |=> !rise_q);
    a_fall_one: assert property (@(posedge clk) disable iff (!reset)
        fall_q |=> !fall_q);

endmodule : debounce_fsm

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm. Two instances (STABLE_TICKS=4 and
// STABLE_TICKS=1) share the same stimulus; a behavioural model per instance
// predicts every output each cycle, and directed scenarios pin the model with
// hand-derived expectations (tick counts, latencies, reset behaviour).
module tb_debounce_fsm;

`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tick  = 1'b0;
    logic raw   = 1'b0;

    always #5 clk = ~clk;

    debounce_fsm_if bus4 ();
    debounce_fsm_if bus1 ();

    assign bus4.tick   = tick;
    assign bus4.raw_in = raw;
    assign bus1.tick   = tick;
    assign bus1.raw_in = raw;

    debounce_fsm #(.STABLE_TICKS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    debounce_fsm #(.STABLE_TICKS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    // Index 0 -> STABLE_TICKS=4 instance, index 1 -> STABLE_TICKS=1 instance.
    logic [1:0] lvl_w, rise_w, fall_w, busy_w;
    assign lvl_w  = {bus1.db_level, bus4.db_level};
    assign rise_w = {bus1.rise,     bus4.rise};
    assign fall_w = {bus1.fall,     bus4.fall};
    assign busy_w = {bus1.busy,     bus4.busy};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model remembers the accepted level, whether the (synchronized)
    // input currently disagrees with it, and how many ticks have been seen
    // while it kept disagreeing. N ticks of disagreement flip the level.
    function automatic int need_ticks(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    logic m_level [2];
    logic m_rise  [2];
    logic m_fall  [2];
    logic m_busy  [2];
    int   m_ticks [2];
    logic p1, p2;   // raw_in as seen one and two edges ago

    always @(posedge clk or negedge reset) begin
        logic s;
        int   t;
        logic lv, bz, r, f;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_level[i] <= 1'b0;
                m_rise[i]  <= 1'b0;
                m_fall[i]  <= 1'b0;
                m_busy[i]  <= 1'b0;
                m_ticks[i] <= 0;
            end
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            s = (SYNC_LAT == 2) ? p2 : raw;
            p2 <= p1;
            p1 <= raw;
            for (int i = 0; i < 2; i++) begin
                lv = m_level[i];
                bz = m_busy[i];
                t  = m_ticks[i];
                r  = 1'b0;
                f  = 1'b0;
                if (!bz) begin
                    if (s != lv) begin
                        bz = 1'b1;
                        t  = 0;
                    end
                end else if (s == lv) begin
                    bz = 1'b0;
                end else if (tick) begin
                    t = t + 1;
                    if (t == need_ticks(i)) begin
                        lv = s;
                        r  = s;
                        f  = !s;
                        bz = 1'b0;
                    end
                end
                m_level[i] <= lv;
                m_busy[i]  <= bz;
                m_ticks[i] <= t;
                m_rise[i]  <= r;
                m_fall[i]  <= f;
            end
        end
    end

    // Compare process: every falling edge, all outputs of both instances.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_level[%0d]", i), 32'(lvl_w[i]),  32'(m_level[i]));
            check($sformatf("model_rise[%0d]", i),  32'(rise_w[i]), 32'(m_rise[i]));
            check($sformatf("model_fall[%0d]", i),  32'(fall_w[i]), 32'(m_fall[i]));
            check($sformatf("model_busy[%0d]", i),  32'(busy_w[i]), 32'(m_busy[i]));
        end
    end

    // ---------------- tick generator ----------------
    // 0: every 21 cycles, 1: random 1-in-4, 2: held high, 3: driven by main.
    int tick_mode = 3;
    int tick_cnt  = 0;

    always @(negedge clk) begin
        case (tick_mode)
            0: begin
                if (tick_cnt >= 20) begin
                    tick     = 1'b1;
                    tick_cnt = 0;
                end else begin
                    tick     = 1'b0;
                    tick_cnt = tick_cnt + 1;
                end
            end
            1:       tick = ($urandom_range(3) == 0);
            2:       tick = 1'b1;
            default: ;
        endcase
    end

    // Main sampling slot: just after the falling edge, once tick is settled.
    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Drive raw to a new level, check WAIT-entry latency, then count the ticks
    // the DUT samples until the edge pulse appears.
    task automatic press_and_qualify(input int idx, input logic to_level,
                                     input int exp_ticks, input string tag);
        int   ticks;
        logic done;
        logic wrong;
        raw = to_level;
        repeat (SYNC_LAT) wait_neg();
        check({tag, "_busy_early"}, 32'(busy_w[idx]), 32'd0);
        wait_neg();
        check({tag, "_busy_entry"}, 32'(busy_w[idx]), 32'd1);
        ticks = 0;
        done  = 1'b0;
        wrong = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (to_level ? fall_w[idx] : rise_w[idx]) wrong = 1'b1;
            if (to_level ? rise_w[idx] : fall_w[idx]) begin
                done = 1'b1;
            end else begin
                if (tick) ticks++;
                wait_neg();
            end
        end
        check({tag, "_done"},        32'(done), 32'd1);
        check({tag, "_ticks"},       32'(ticks), 32'(exp_ticks));
        check({tag, "_level"},       32'(lvl_w[idx]), 32'(to_level));
        check({tag, "_busy_after"},  32'(busy_w[idx]), 32'd0);
        check({tag, "_other_pulse"}, 32'(to_level ? fall_w[idx] : rise_w[idx]), 32'd0);
        check({tag, "_wrong_pulse"}, 32'(wrong), 32'd0);
        wait_neg();
        check({tag, "_pulse_1cyc"},  32'(to_level ? rise_w[idx] : fall_w[idx]), 32'd0);
    endtask

    task automatic wait_busy(input int idx, input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (busy_w[idx]) seen = 1'b1;
            else wait_neg();
        end
        check({tag, "_busy_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        logic any_rise;
        int   hold;

        // Reset state
        repeat (3) wait_neg();
        check("rst_level", 32'(lvl_w[0]),  32'd0);
        check("rst_rise",  32'(rise_w[0]), 32'd0);
        check("rst_fall",  32'(fall_w[0]), 32'd0);
        check("rst_busy",  32'(busy_w[0]), 32'd0);
        reset = 1'b1;
        wait_neg();

        // Clean press, then release, with a 21-cycle tick period
        tick_mode = 0;
        repeat (7) wait_neg();
        press_and_qualify(0, 1'b1, 4, "press");
        repeat (30) wait_neg();
        press_and_qualify(0, 1'b0, 4, "release");
        repeat (30) wait_neg();

        // Bounce 1,0,1 every 10 cycles: aborts, then restarts from the final 1
        any_rise = 1'b0;
        raw = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rise_w[0]) any_rise = 1'b1;
            wait_neg();
        end
        raw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rise_w[0]) any_rise = 1'b1;
            wait_neg();
        end
        check("bounce_no_rise", 32'(any_rise), 32'd0);
        check("bounce_level",   32'(lvl_w[0]), 32'd0);
        check("bounce_aborted", 32'(busy_w[0]), 32'd0);
        press_and_qualify(0, 1'b1, 4, "bounce");
        repeat (10) wait_neg();
        press_and_qualify(0, 1'b0, 4, "release2");
        repeat (10) wait_neg();

        // Collision: cnt=3 and sync_in drops on the same edge as a tick
        tick_mode = 3;
        tick = 1'b0;
        wait_neg();
        raw = 1'b1;
        wait_busy(0, "coll");
        for (int k = 0; k < 3; k++) begin
            tick = 1'b1;
            wait_neg();
            tick = 1'b0;
            wait_neg();
        end
        check("coll_still_busy", 32'(busy_w[0]), 32'd1);
        raw = 1'b0;
        repeat (SYNC_LAT) wait_neg();
        tick = 1'b1;
        wait_neg();
        tick = 1'b0;
        check("coll_busy",  32'(busy_w[0]), 32'd0);
        check("coll_rise",  32'(rise_w[0]), 32'd0);
        check("coll_level", 32'(lvl_w[0]),  32'd0);
        any_rise = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rise_w[0]) any_rise = 1'b1;
            wait_neg();
        end
        check("coll_no_late_rise", 32'(any_rise), 32'd0);

        // Reset asserted between edges while qualifying
        tick_mode = 0;
        raw = 1'b1;
        wait_busy(0, "rstmid");
        repeat (3) wait_neg();
        check("rstmid_busy_before", 32'(busy_w[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstmid_level", 32'(lvl_w[0]),  32'd0);
        check("rstmid_rise",  32'(rise_w[0]), 32'd0);
        check("rstmid_fall",  32'(fall_w[0]), 32'd0);
        check("rstmid_busy",  32'(busy_w[0]), 32'd0);
        wait_neg();
        reset = 1'b1;
        press_and_qualify(0, 1'b1, 4, "post_reset");

        // STABLE_TICKS=1 instance: fresh reset with raw low
        raw = 1'b0;
        wait_neg();
        reset = 1'b0;
        wait_neg();
        reset = 1'b1;
        repeat (3) wait_neg();
        press_and_qualify(1, 1'b1, 1, "n1_press");
        repeat (5) wait_neg();
        press_and_qualify(1, 1'b0, 1, "n1_release");
        repeat (5) wait_neg();

        // Tick held high: rise two cycles (plus sync latency) after raw change
        tick_mode = 2;
        wait_neg();
        raw = 1'b1;
        repeat (SYNC_LAT + 1) wait_neg();
        check("n1_cont_rise_early", 32'(rise_w[1]), 32'd0);
        wait_neg();
        check("n1_cont_rise", 32'(rise_w[1]), 32'd1);
        repeat (5) wait_neg();

        // Randomized tail: random ticks and random hold lengths
        tick_mode = 1;
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                raw  = 1'($urandom_range(1));
                hold = $urandom_range(40, 1);
            end
            hold--;
            wait_neg();
        end

        repeat (3) wait_neg();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_debounce_fsm
